nettlp_eth_rx: RTL and testbench

- Receive-side de-encapsulator for NetTLP; inverse of the TX packet builder.
- Consumes 64-bit Ethernet RX AXI-stream frames from the 10G subsystem and parses Eth/IPv4/UDP/NetTLP headers (beats 0-5).
- Filters on UDP destination port and forwards the encapsulated TLP, starting at beat 6, into the PCIe TX FIFO as PCIE_FIFO64_TX words.
- Latches NetTLP seq/tstamp and keeps drop/error counters for the register block.

---
 rtl/nettlp_pkg.sv | 63 ++++++
 rtl/nettlp_rx_hdr_check.sv | 52 +++++
 rtl/nettlp_eth_rx.sv | 174 +++++++++++++++++
 tb/tb_nettlp_eth_rx.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nettlp_pkg.sv
// Shared NetTLP definitions: Ethernet/IPv4/UDP/NetTLP qword views of the RX stream
// and the PCIe TX FIFO word layout.
package nettlp_pkg;

  localparam logic [15:0] ETHERTYPE_IPV4   = 16'h0800;
  localparam logic [7:0]  IPPROTO_UDP      = 8'd17;
  localparam logic [2:0]  NETTLP_HDR_BEATS = 3'd6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2,
    DROP    = 2'd3
  } ETH_RX_STATE;

  typedef logic [63:0] ETH_TDATA64;

  // Wire bytes 8-15: tail of eth.src, ethertype, IPv4 version/ihl, tos
  typedef struct packed {
    logic [31:0] src_lo;
    logic [15:0] h_proto;
    logic [3:0]  version;
    logic [3:0]  ihl;
    logic [7:0]  tos;
  } PACKET_QWORD1;

  typedef struct packed {
    logic [15:0] tot_len;
    logic [15:0] id;
    logic [15:0] frag_off;
    logic [7:0]  ttl;
    logic [7:0]  protocol;
  } PACKET_QWORD2;

  typedef struct packed {
    logic [15:0] check;
    logic [31:0] saddr;
    logic [15:0] daddr_hi;
  } PACKET_QWORD3;

  typedef struct packed {
    logic [15:0] daddr_lo;
    logic [15:0] source;
    logic [15:0] dest;
    logic [15:0] len;
  } PACKET_QWORD4;

  typedef struct packed {
    logic [15:0] check;
    logic [15:0] seq;
    logic [31:0] tstamp;
  } PACKET_QWORD5;

  // tuser[2] is src_dsc (discontinue)
  typedef struct packed {
    logic        tvalid;
    logic [3:0]  tuser;
    logic        tlast;
    logic [7:0]  tkeep;
    logic [63:0] tdata;
  } PCIE_FIFO64_TX;

endpackage

// File: rtl/nettlp_rx_hdr_check.sv
// Per-beat header match accumulator: folds Eth/IPv4/UDP checks for beats 1-4 into
// a single registered match flag and classifies the UDP destination port.
module nettlp_rx_hdr_check
  import nettlp_pkg::*;
#(
  parameter logic [15:0] UDP_PORT_CPL = 16'h3000,
  parameter logic [15:0] UDP_PORT_MR  = 16'h4000,
  parameter logic [15:0] PORT_MASK    = 16'hF000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        beat_en,
  input  logic [2:0]  beat,
  input  logic [63:0] data,
  output logic        match,
  output logic        pkt_type
);

  PACKET_QWORD1 q1_s;
  PACKET_QWORD2 q2_s;
  PACKET_QWORD4 q4_s;
  logic [15:0]  dport_s;
  logic         unused_s;

  assign q1_s    = PACKET_QWORD1'(data);
  assign q2_s    = PACKET_QWORD2'(data);
  assign q4_s    = PACKET_QWORD4'(data);
  assign dport_s = q4_s.dest & PORT_MASK;
  assign unused_s = ^{q1_s.src_lo, q1_s.tos, q2_s.tot_len, q2_s.id, q2_s.frag_off,
                      q2_s.ttl, q4_s.daddr_lo, q4_s.source, q4_s.len};

  // Beat 0 opens a new frame with match set; later beats can only clear it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      match    <= 1'b0;
      pkt_type <= 1'b0;
    end else if (beat_en) begin
      case (beat)
        3'd0: match <= 1'b1;
        3'd1: match <= match && (q1_s.h_proto == ETHERTYPE_IPV4) &&
                       (q1_s.version == 4'd4) && (q1_s.ihl == 4'd5);
        3'd2: match <= match && (q2_s.protocol == IPPROTO_UDP);
        3'd4: begin
          match    <= match && ((dport_s == UDP_PORT_CPL) || (dport_s == UDP_PORT_MR));
          pkt_type <= (dport_s == UDP_PORT_MR);
        end
        default: match <= match;
      endcase
    end
  end

endmodule

// File: rtl/nettlp_eth_rx.sv
// NetTLP receive de-encapsulator: strips Eth/IPv4/UDP/NetTLP headers from the
// 10G RX stream and forwards the carried TLP into the PCIe TX FIFO.
module nettlp_eth_rx
  import nettlp_pkg::*;
#(
  parameter logic [15:0] UDP_PORT_CPL = 16'h3000,
  parameter logic [15:0] UDP_PORT_MR  = 16'h4000,
  parameter logic [15:0] PORT_MASK    = 16'hF000,
  parameter int          CNT_W        = 32
) (
  input  logic             eth_clk,
  input  logic             eth_rst_n,
  input  logic             eth_rx_tvalid,
  input  logic             eth_rx_tlast,
  input  logic [7:0]       eth_rx_tkeep,
  input  logic [63:0]      eth_rx_tdata,
  input  logic             eth_rx_tuser,
  output logic [77:0]      fifo_din,
  output logic             fifo_wr_en,
  input  logic             fifo_full,
  input  logic             fifo_prog_full,
  output logic             pkt_type,
  output logic             pkt_valid,
  output logic [15:0]      last_seq,
  output logic [31:0]      last_tstamp,
  output logic [CNT_W-1:0] cnt_rx_ok,
  output logic [CNT_W-1:0] cnt_drop,
  output logic [CNT_W-1:0] cnt_err
);

  ETH_RX_STATE   state_r;
  logic [2:0]    beat_r;
  logic          ovf_r;
  logic          match_s;
  logic          hdr_type_s;
  logic          chk_en_s;
  logic [2:0]    chk_beat_s;
  logic          tail_bad_s;
  logic          pay_err_s;
  logic          wr_s;
  logic          dsc_s;
  logic [7:0]    keep_s;
  PCIE_FIFO64_TX word_s;
  PACKET_QWORD5  q5_s;
  logic          unused_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) return v;
    else return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign q5_s       = PACKET_QWORD5'(ETH_TDATA64'(eth_rx_tdata));
  assign unused_s   = ^q5_s.check;
  assign chk_en_s   = eth_rx_tvalid && ((state_r == IDLE) || (state_r == HDR));
  assign chk_beat_s = (state_r == IDLE) ? 3'd0 : beat_r;
  assign tail_bad_s = eth_rx_tuser || !((eth_rx_tkeep == 8'hFF) || (eth_rx_tkeep == 8'hF0));
  assign pay_err_s  = ovf_r || fifo_full || tail_bad_s;

  nettlp_rx_hdr_check #(
    .UDP_PORT_CPL (UDP_PORT_CPL),
    .UDP_PORT_MR  (UDP_PORT_MR),
    .PORT_MASK    (PORT_MASK)
  ) u_hdr_check (
    .clk      (eth_clk),
    .rst_n    (eth_rst_n),
    .beat_en  (chk_en_s),
    .beat     (chk_beat_s),
    .data     (eth_rx_tdata),
    .match    (match_s),
    .pkt_type (hdr_type_s)
  );

  // Payload write path: dword swap into the FIFO layout, overflow suppression, tail marking
  always_comb begin
    wr_s   = 1'b0;
    dsc_s  = 1'b0;
    keep_s = {eth_rx_tkeep[3:0], eth_rx_tkeep[7:4]};
    if ((state_r == PAYLOAD) && eth_rx_tvalid) begin
      if (eth_rx_tlast) begin
        wr_s  = !fifo_full;
        dsc_s = ovf_r || tail_bad_s;
        if (tail_bad_s) keep_s = 8'hFF;
        else keep_s = {eth_rx_tkeep[3:0], eth_rx_tkeep[7:4]};
      end else begin
        wr_s  = !fifo_full && !ovf_r;
        dsc_s = 1'b0;
      end
    end else begin
      wr_s  = 1'b0;
      dsc_s = 1'b0;
    end
    word_s.tvalid = 1'b1;
    word_s.tuser  = {1'b0, dsc_s, 2'b00};
    word_s.tlast  = eth_rx_tlast;
    word_s.tkeep  = keep_s;
    word_s.tdata  = {eth_rx_tdata[31:0], eth_rx_tdata[63:32]};
  end

  // Frame FSM, registered FIFO outputs, header latches and saturating counters
  always_ff @(posedge eth_clk) begin
    if (!eth_rst_n) begin
      state_r     <= IDLE;
      beat_r      <= 3'd0;
      ovf_r       <= 1'b0;
      fifo_wr_en  <= 1'b0;
      fifo_din    <= 78'd0;
      pkt_valid   <= 1'b0;
      pkt_type    <= 1'b0;
      last_seq    <= 16'd0;
      last_tstamp <= 32'd0;
      cnt_rx_ok   <= {CNT_W{1'b0}};
      cnt_drop    <= {CNT_W{1'b0}};
      cnt_err     <= {CNT_W{1'b0}};
    end else begin
      fifo_wr_en <= wr_s;
      if (wr_s) fifo_din <= word_s;
      pkt_valid <= 1'b0;
      if (eth_rx_tvalid) begin
        case (state_r)
          IDLE: begin
            if (eth_rx_tlast) begin
              cnt_drop <= sat_inc(cnt_drop);
            end else begin
              state_r <= HDR;
              beat_r  <= 3'd1;
            end
          end
          HDR: begin
            if (eth_rx_tlast) begin
              state_r  <= IDLE;
              beat_r   <= 3'd0;
              cnt_drop <= sat_inc(cnt_drop);
            end else if (beat_r == (NETTLP_HDR_BEATS - 3'd1)) begin
              beat_r <= 3'd0;
              ovf_r  <= 1'b0;
              if (!match_s || fifo_prog_full) begin
                state_r <= DROP;
              end else begin
                state_r     <= PAYLOAD;
                pkt_valid   <= 1'b1;
                pkt_type    <= hdr_type_s;
                last_seq    <= q5_s.seq;
                last_tstamp <= q5_s.tstamp;
              end
            end else begin
              beat_r <= beat_r + 3'd1;
            end
          end
          PAYLOAD: begin
            if (eth_rx_tlast) begin
              state_r <= IDLE;
              ovf_r   <= 1'b0;
              if (pay_err_s) cnt_err <= sat_inc(cnt_err);
              else cnt_rx_ok <= sat_inc(cnt_rx_ok);
            end else if (fifo_full) begin
              ovf_r <= 1'b1;
            end
          end
          DROP: begin
            if (eth_rx_tlast) begin
              state_r  <= IDLE;
              cnt_drop <= sat_inc(cnt_drop);
            end
          end
          default: begin
            state_r <= IDLE;
            beat_r  <= 3'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nettlp_eth_rx.sv
// Self-checking bench for nettlp_eth_rx: directed scenarios plus randomized frames
// checked against a byte-level model of the NetTLP receive rules.
module tb_nettlp_eth_rx;

  logic        eth_clk = 1'b0;
  logic        eth_rst_n = 1'b0;
  logic        eth_rx_tvalid = 1'b0;
  logic        eth_rx_tlast = 1'b0;
  logic [7:0]  eth_rx_tkeep = 8'h00;
  logic [63:0] eth_rx_tdata = 64'd0;
  logic        eth_rx_tuser = 1'b0;
  logic        fifo_full = 1'b0;
  logic        fifo_prog_full = 1'b0;
  logic [77:0] fifo_din;
  logic        fifo_wr_en;
  logic        pkt_type;
  logic        pkt_valid;
  logic [15:0] last_seq;
  logic [31:0] last_tstamp;
  logic [31:0] cnt_rx_ok;
  logic [31:0] cnt_drop;
  logic [31:0] cnt_err;

  always #3 eth_clk = ~eth_clk;

  nettlp_eth_rx dut (
    .eth_clk(eth_clk), .eth_rst_n(eth_rst_n),
    .eth_rx_tvalid(eth_rx_tvalid), .eth_rx_tlast(eth_rx_tlast), .eth_rx_tkeep(eth_rx_tkeep),
    .eth_rx_tdata(eth_rx_tdata), .eth_rx_tuser(eth_rx_tuser),
    .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full),
    .fifo_prog_full(fifo_prog_full), .pkt_type(pkt_type), .pkt_valid(pkt_valid),
    .last_seq(last_seq), .last_tstamp(last_tstamp),
    .cnt_rx_ok(cnt_rx_ok), .cnt_drop(cnt_drop), .cnt_err(cnt_err)
  );

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Stimulus frame under construction
  logic [63:0] f_data[$];
  logic [7:0]  f_keep[$];
  bit          f_full[$];
  bit          f_pfull;
  bit          f_tuser;

  // Reference model state
  logic [31:0] m_ok, m_drop, m_err, m_ts;
  logic [15:0] m_seq;
  logic [77:0] exp_q[$];
  bit          exp_types[$];

  // Observed DUT traffic
  logic [77:0] got_q[$];
  bit          got_types[$];

  always @(negedge eth_clk) begin
    if (fifo_wr_en) got_q.push_back(fifo_din);
    if (pkt_valid) got_types.push_back(pkt_type);
  end

  function automatic logic [7:0] byte_at(int i);
    logic [63:0] w;
    w = f_data[i / 8];
    return w[63 - 8 * (i % 8) -: 8];
  endfunction

  task automatic build(input logic [15:0] dport, input logic [15:0] etype, input logic [7:0] proto,
                       input logic [15:0] seq, input logic [31:0] ts, input int npay,
                       input logic [7:0] lkeep);
    logic [7:0]  hb[48];
    logic [63:0] w;
    f_data.delete(); f_keep.delete(); f_full.delete();
    f_pfull = 1'b0; f_tuser = 1'b0;
    for (int i = 0; i < 48; i++) hb[i] = 8'($urandom);
    hb[12] = etype[15:8]; hb[13] = etype[7:0]; hb[14] = 8'h45; hb[23] = proto;
    hb[36] = dport[15:8]; hb[37] = dport[7:0];
    hb[42] = seq[15:8];   hb[43] = seq[7:0];
    hb[44] = ts[31:24]; hb[45] = ts[23:16]; hb[46] = ts[15:8]; hb[47] = ts[7:0];
    for (int b = 0; b < 6; b++) begin
      w = 64'd0;
      for (int j = 0; j < 8; j++) w = {w[55:0], hb[8 * b + j]};
      f_data.push_back(w); f_keep.push_back(8'hFF); f_full.push_back(1'b0);
    end
    for (int p = 0; p < npay; p++) begin
      f_data.push_back({$urandom, $urandom});
      f_keep.push_back((p == npay - 1) ? lkeep : 8'hFF);
      f_full.push_back(1'b0);
    end
  endtask

  // Expected outcome of the current frame, from byte offsets in the Ethernet frame
  task automatic model_frame();
    int n;
    logic [15:0] etype, dport;
    logic [63:0] d;
    logic [7:0]  k;
    bit ovf, bad, last;
    n = f_data.size();
    if (n <= 6) begin m_drop = m_drop + 1; return; end
    etype = {byte_at(12), byte_at(13)};
    dport = {byte_at(36), byte_at(37)} & 16'hF000;
    if (etype != 16'h0800 || byte_at(14) != 8'h45 || byte_at(23) != 8'd17 ||
        !(dport == 16'h3000 || dport == 16'h4000) || f_pfull) begin
      m_drop = m_drop + 1; return;
    end
    exp_types.push_back(dport == 16'h4000);
    m_seq = {byte_at(42), byte_at(43)};
    m_ts  = {byte_at(44), byte_at(45), byte_at(46), byte_at(47)};
    bad = f_tuser || !(f_keep[n - 1] == 8'hFF || f_keep[n - 1] == 8'hF0);
    ovf = 1'b0;
    for (int b = 6; b < n; b++) begin
      last = (b == n - 1);
      d = 64'd0;
      for (int j = 4; j < 8; j++) d = {d[55:0], byte_at(8 * b + j)};
      for (int j = 0; j < 4; j++) d = {d[55:0], byte_at(8 * b + j)};
      k = (last && bad) ? 8'hFF : (f_keep[b] == 8'hF0) ? 8'h0F : 8'hFF;
      if (last) begin
        if (!f_full[b]) exp_q.push_back({1'b1, 1'b0, (ovf || bad), 2'b00, 1'b1, k, d});
        if (ovf || f_full[b] || bad) m_err = m_err + 1;
        else m_ok = m_ok + 1;
      end else if (f_full[b] || ovf) begin
        ovf = 1'b1;
      end else begin
        exp_q.push_back({1'b1, 4'b0000, 1'b0, k, d});
      end
    end
  endtask

  task automatic drive_beat(input int i);
    int n;
    n = f_data.size();
    eth_rx_tvalid  = 1'b1;
    eth_rx_tdata   = f_data[i];
    eth_rx_tkeep   = f_keep[i];
    eth_rx_tlast   = (i == n - 1);
    eth_rx_tuser   = (i == n - 1) && f_tuser;
    fifo_full      = f_full[i];
    fifo_prog_full = (i == 5) && f_pfull;
  endtask

  task automatic send_beats(input int from, input int to);
    for (int i = from; i <= to; i++) begin
      @(posedge eth_clk); #1;
      drive_beat(i);
    end
  endtask

  task automatic end_drive();
    @(posedge eth_clk); #1;
    eth_rx_tvalid = 1'b0; eth_rx_tlast = 1'b0; eth_rx_tuser = 1'b0;
    fifo_full = 1'b0; fifo_prog_full = 1'b0;
  endtask

  task automatic clear_queues();
    got_q.delete(); exp_q.delete(); got_types.delete(); exp_types.delete();
  endtask

  task automatic test_reset();
    chk_cnt++; if (fifo_wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b want 0", fifo_wr_en); else pass_cnt++;
    chk_cnt++; if (fifo_din !== 78'd0) $display("FAIL reset_din: got %h want 0", fifo_din); else pass_cnt++;
    chk_cnt++; if ({pkt_valid, pkt_type} !== 2'b00) $display("FAIL reset_pkt: got %b want 00", {pkt_valid, pkt_type}); else pass_cnt++;
    chk_cnt++; if ({last_seq, last_tstamp} !== 48'd0) $display("FAIL reset_last: got %h want 0", {last_seq, last_tstamp}); else pass_cnt++;
    chk_cnt++; if ({cnt_rx_ok, cnt_drop, cnt_err} !== 96'd0) $display("FAIL reset_cnt: got %0d/%0d/%0d want 0/0/0", cnt_rx_ok, cnt_drop, cnt_err); else pass_cnt++;
  endtask

  task automatic test_mr_frame();
    build(16'h4000, 16'h0800, 8'd17, 16'h0012, 32'hDEADBEEF, 3, 8'hF0);
    model_frame();
    send_beats(0, f_data.size() - 1); end_drive(); repeat (3) @(negedge eth_clk);
    chk_cnt++; if (got_q.size() != 3) $display("FAIL mr_writes: got %0d want 3", got_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      chk_cnt++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) $display("FAIL mr_word%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 78'hx, exp_q[i]);
      else pass_cnt++;
    end
    chk_cnt++; if (got_q.size() < 3 || got_q[2][72:64] !== 9'h10F) $display("FAIL mr_tail_last_keep: got %h want 10f", (got_q.size() < 3) ? 9'hx : got_q[2][72:64]); else pass_cnt++;
    chk_cnt++; if (got_types.size() != 1 || got_types[0] !== 1'b1) $display("FAIL mr_pkt_type: got %0d pulses want 1 with type 1", got_types.size()); else pass_cnt++;
    chk_cnt++; if (last_seq !== 16'h0012 || last_tstamp !== 32'hDEADBEEF) $display("FAIL mr_seq_ts: got %h/%h want 0012/deadbeef", last_seq, last_tstamp); else pass_cnt++;
    chk_cnt++; if (cnt_rx_ok !== 32'd1) $display("FAIL mr_rx_ok: got %0d want 1", cnt_rx_ok); else pass_cnt++;
    clear_queues();
  endtask

  task automatic test_filtered();
    logic [15:0] dp[3] = '{16'h5000, 16'h4000, 16'h4000};
    logic [15:0] et[3] = '{16'h0800, 16'h86DD, 16'h0800};
    logic [7:0]  pr[3] = '{8'd17, 8'd17, 8'd6};
    for (int i = 0; i < 3; i++) begin
      build(dp[i], et[i], pr[i], 16'($urandom), $urandom, 2, 8'hFF);
      model_frame();
      send_beats(0, f_data.size() - 1); end_drive(); repeat (2) @(negedge eth_clk);
    end
    chk_cnt++; if (got_q.size() != 0 || got_types.size() != 0) $display("FAIL filt_writes: got %0d writes want 0", got_q.size()); else pass_cnt++;
    chk_cnt++; if (cnt_drop !== 32'd3) $display("FAIL filt_drop: got %0d want 3", cnt_drop); else pass_cnt++;
    chk_cnt++; if (cnt_rx_ok !== m_ok) $display("FAIL filt_rx_ok: got %0d want %0d", cnt_rx_ok, m_ok); else pass_cnt++;
    clear_queues();
  endtask

  task automatic test_runt_back_to_back();
    build(16'h4000, 16'h0800, 8'd17, 16'h1111, 32'h1, 2, 8'hFF);
    f_data = f_data[0:3]; f_keep = f_keep[0:3]; f_full = f_full[0:3];
    model_frame();
    send_beats(0, 3);
    build(16'h3000, 16'h0800, 8'd17, 16'hBEEF, $urandom, 2, 8'hF0);
    model_frame();
    send_beats(0, f_data.size() - 1); end_drive(); repeat (3) @(negedge eth_clk);
    chk_cnt++; if (cnt_drop !== 32'd4) $display("FAIL runt_drop: got %0d want 4", cnt_drop); else pass_cnt++;
    chk_cnt++; if (cnt_rx_ok !== 32'd2) $display("FAIL b2b_rx_ok: got %0d want 2", cnt_rx_ok); else pass_cnt++;
    chk_cnt++; if (got_types.size() != 1 || got_types[0] !== 1'b0) $display("FAIL b2b_pkt_type: got %0d pulses want 1 with type 0", got_types.size()); else pass_cnt++;
    chk_cnt++; if (got_q != exp_q) $display("FAIL b2b_words: got %0d words want %0d", got_q.size(), exp_q.size()); else pass_cnt++;
    chk_cnt++; if (last_seq !== 16'hBEEF) $display("FAIL b2b_seq: got %h want beef", last_seq); else pass_cnt++;
    clear_queues();
  endtask

  task automatic test_tuser_err();
    build(16'h4000, 16'h0800, 8'd17, 16'h0042, $urandom, 2, 8'hFF);
    f_tuser = 1'b1;
    model_frame();
    send_beats(0, f_data.size() - 1); end_drive(); repeat (3) @(negedge eth_clk);
    chk_cnt++; if (got_q.size() != 2 || got_q[1][75] !== 1'b1 || got_q[0][75] !== 1'b0) $display("FAIL tuser_dsc: got %0d writes want 2 with dsc on last only", got_q.size()); else pass_cnt++;
    chk_cnt++; if (got_q != exp_q) $display("FAIL tuser_words: got %0d words want %0d", got_q.size(), exp_q.size()); else pass_cnt++;
    chk_cnt++; if (cnt_err !== 32'd1 || cnt_rx_ok !== 32'd2) $display("FAIL tuser_cnt: got err %0d ok %0d want 1/2", cnt_err, cnt_rx_ok); else pass_cnt++;
    clear_queues();
  endtask

  task automatic test_prog_full_overflow();
    build(16'h3000, 16'h0800, 8'd17, 16'h0777, $urandom, 2, 8'hFF);
    f_pfull = 1'b1;
    model_frame();
    send_beats(0, f_data.size() - 1); end_drive(); repeat (2) @(negedge eth_clk);
    chk_cnt++; if (got_q.size() != 0 || cnt_drop !== 32'd5) $display("FAIL pfull_drop: got %0d writes drop %0d want 0/5", got_q.size(), cnt_drop); else pass_cnt++;
    build(16'h4000, 16'h0800, 8'd17, 16'h0888, $urandom, 4, 8'hFF);
    f_full[7] = 1'b1;
    model_frame();
    send_beats(0, f_data.size() - 1); end_drive(); repeat (3) @(negedge eth_clk);
    chk_cnt++; if (got_q.size() != 2 || got_q[1][75] !== 1'b1 || got_q[0][75] !== 1'b0) $display("FAIL ovf_writes: got %0d writes want 2 with dsc on last", got_q.size()); else pass_cnt++;
    chk_cnt++; if (got_q != exp_q) $display("FAIL ovf_words: got %0d words want %0d", got_q.size(), exp_q.size()); else pass_cnt++;
    chk_cnt++; if (cnt_err !== 32'd2 || cnt_rx_ok !== 32'd2) $display("FAIL ovf_cnt: got err %0d ok %0d want 2/2", cnt_err, cnt_rx_ok); else pass_cnt++;
    clear_queues();
  endtask

  task automatic test_mid_reset();
    build(16'h4000, 16'h0800, 8'd17, 16'h0999, $urandom, 3, 8'hFF);
    send_beats(0, 6);
    @(posedge eth_clk); #1; drive_beat(7); eth_rst_n = 1'b0;
    @(posedge eth_clk); #1; eth_rst_n = 1'b1; drive_beat(8);
    @(negedge eth_clk);
    chk_cnt++; if ({cnt_rx_ok, cnt_drop, cnt_err} !== 96'd0) $display("FAIL rst_cnt: got %0d/%0d/%0d want 0/0/0", cnt_rx_ok, cnt_drop, cnt_err); else pass_cnt++;
    chk_cnt++; if ({last_seq, last_tstamp} !== 48'd0 || {pkt_valid, pkt_type, fifo_wr_en} !== 3'b000 || fifo_din !== 78'd0) $display("FAIL rst_outputs: got seq %h wr %b din %h want all 0", last_seq, fifo_wr_en, fifo_din); else pass_cnt++;
    clear_queues();
    m_ok = 32'd0; m_err = 32'd0; m_drop = 32'd0;
    end_drive(); repeat (2) @(negedge eth_clk);
    // The interrupted frame's tail beat lands in IDLE carrying tlast: a one-beat runt
    m_drop = 32'd1;
    chk_cnt++; if (got_q.size() != 0 || cnt_drop !== m_drop) $display("FAIL rst_tail_drop: got %0d writes drop %0d want 0/1", got_q.size(), cnt_drop); else pass_cnt++;
    build(16'h3000, 16'h0800, 8'd17, 16'h0ABC, $urandom, 2, 8'hF0);
    model_frame();
    send_beats(0, f_data.size() - 1); end_drive(); repeat (3) @(negedge eth_clk);
    chk_cnt++; if (got_q != exp_q || got_q.size() != 2) $display("FAIL rst_next_words: got %0d words want 2", got_q.size()); else pass_cnt++;
    chk_cnt++; if (cnt_rx_ok !== 32'd1 || last_seq !== 16'h0ABC) $display("FAIL rst_next_cnt: got ok %0d seq %h want 1/0abc", cnt_rx_ok, last_seq); else pass_cnt++;
    clear_queues();
  endtask

  task automatic test_random();
    logic [15:0] dports[5] = '{16'h3000, 16'h4000, 16'h5000, 16'h3ABC, 16'h4FFF};
    logic [7:0]  lk;
    int npay, gap;
    for (int f = 0; f < 40; f++) begin
      case ($urandom_range(0, 3))
        0, 1: lk = 8'hFF;
        2: lk = 8'hF0;
        default: lk = 8'($urandom);
      endcase
      npay = $urandom_range(1, 6);
      build(dports[$urandom_range(0, 4)], ($urandom_range(0, 9) == 0) ? 16'h86DD : 16'h0800,
            ($urandom_range(0, 9) == 0) ? 8'd6 : 8'd17, 16'($urandom), $urandom, npay, lk);
      if ($urandom_range(0, 7) == 0) begin
        f_data = f_data[0:$urandom_range(0, 5)];
        f_keep = f_keep[0:f_data.size() - 1]; f_full = f_full[0:f_data.size() - 1];
      end
      f_pfull = ($urandom_range(0, 7) == 0);
      f_tuser = ($urandom_range(0, 7) == 0);
      for (int b = 6; b < f_full.size(); b++) f_full[b] = ($urandom_range(0, 5) == 0);
      model_frame();
      send_beats(0, f_data.size() - 1);
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        end_drive();
        repeat (gap - 1) @(posedge eth_clk);
      end
    end
    end_drive(); repeat (3) @(negedge eth_clk);
    chk_cnt++; if (got_q.size() != exp_q.size()) $display("FAIL rnd_nwrites: got %0d want %0d", got_q.size(), exp_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      chk_cnt++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) $display("FAIL rnd_word%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 78'hx, exp_q[i]);
      else pass_cnt++;
    end
    chk_cnt++; if (got_types != exp_types) $display("FAIL rnd_types: got %0d pulses want %0d", got_types.size(), exp_types.size()); else pass_cnt++;
    chk_cnt++; if (cnt_rx_ok !== m_ok || cnt_drop !== m_drop || cnt_err !== m_err) $display("FAIL rnd_cnt: got %0d/%0d/%0d want %0d/%0d/%0d", cnt_rx_ok, cnt_drop, cnt_err, m_ok, m_drop, m_err); else pass_cnt++;
    chk_cnt++; if (last_seq !== m_seq || last_tstamp !== m_ts) $display("FAIL rnd_seq_ts: got %h/%h want %h/%h", last_seq, last_tstamp, m_seq, m_ts); else pass_cnt++;
    clear_queues();
  endtask

  initial begin
    m_ok = 32'd0; m_drop = 32'd0; m_err = 32'd0; m_seq = 16'd0; m_ts = 32'd0;
    repeat (3) @(posedge eth_clk);
    #1 eth_rst_n = 1'b1;
    @(negedge eth_clk);
    test_reset();
    test_mr_frame();
    test_filtered();
    test_runt_back_to_back();
    test_tuser_err();
    test_prog_full_overflow();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
